// File: rtl/ula_seq_pkg.sv
// ula_seq_pkg: shared definitions for the ALU operation sequencer.
//   - opcode constants and class boundaries for the 4-bit ALU select code
//   - op_class_e class encoding and the op_class() helper
//   - state_e sequencer state enum
// The macro ULA_SEQ_OVF_TRAP_EN adds the HALT state used by the overflow trap.
package ula_seq_pkg;

    localparam logic [3:0] OP_ADD        = 4'h0;
    localparam logic [3:0] OP_SUB        = 4'h1;
    localparam logic [3:0] OP_MUL        = 4'h2;
    localparam logic [3:0] OP_ARITH_LAST = 4'h4;
    localparam logic [3:0] OP_LOGIC_LAST = 4'h7;
    localparam logic [3:0] OP_NOT        = 4'h8;
    localparam logic [3:0] OP_EQ         = 4'h9;
    localparam logic [3:0] OP_CMP_LAST   = 4'hE;
    localparam logic [3:0] OP_ILLEGAL    = 4'hF;

    typedef enum logic [1:0] {
        CLS_ARITH,
        CLS_LOGIC,
        CLS_UNARY,
        CLS_CMP
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD1,
        ST_LD1,
        ST_LD2,
        ST_EXEC,
        ST_DONE
`ifdef ULA_SEQ_OVF_TRAP_EN
        , ST_HALT
`endif
    } state_e;

    // The illegal code falls into CLS_CMP here; callers check it separately.
    function automatic op_class_e op_class(input logic [3:0] op);
        if (op <= OP_ARITH_LAST)      return CLS_ARITH;
        else if (op <= OP_LOGIC_LAST) return CLS_LOGIC;
        else if (op == OP_NOT)        return CLS_UNARY;
        else                          return CLS_CMP;
    endfunction

endpackage

// File: rtl/ula_op_decode.sv
// ula_op_decode: combinational opcode classifier.
//   op_code    in  4  ALU select code
//   arity      out 2  number of stack operands consumed (1 or 2)
//   is_arith   out 1  overflow-tracked arithmetic op
//   is_cmp     out 1  compare op (writes the comparison stack)
//   is_unary   out 1  single-operand op (NOT)
//   is_illegal out 1  reserved code 1111
module ula_op_decode
    import ula_seq_pkg::*;
(
    input  logic [3:0] op_code,
    output logic [1:0] arity,
    output logic       is_arith,
    output logic       is_cmp,
    output logic       is_unary,
    output logic       is_illegal
);

    op_class_e cls;

    always_comb begin
        cls        = op_class(op_code);
        is_illegal = (op_code == OP_ILLEGAL);
        is_arith   = (cls == CLS_ARITH);
        is_unary   = (cls == CLS_UNARY);
        is_cmp     = (cls == CLS_CMP) && !is_illegal;
        arity      = is_unary ? 2'd1 : 2'd2;
    end

endmodule

// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer: steps one ALU operation through operand reads, execute
// and stack write-back, tracking the operand-stack depth (TOS).
//   clk, rst_n                 clock, synchronous active-low reset
//   OP_VALID_IN/OP_READY_OUT   request handshake, OP_CODE_IN the ALU code
//   DONE_OUT / ERR_OUT         one-cycle retire / reject pulses
//   TOS_SET_IN/TOS_SET_VAL_IN  load the depth counter (IDLE only)
//   TOS_OUT                    current depth; top entry lives at TOS-1
//   STACK_ADDR_OUT/STACK_WR_OUT operand-stack address and write enable
//   CTRL_REG_*/CTRL_STACK_COMP_OUT ALU operand/overflow/compare enables
//   SEL_ULA_OUT                ALU select, OVF_IN registered overflow flag
// Build option ULA_SEQ_OVF_TRAP_EN adds TRAP_OUT/TRAP_CLR_IN and a HALT state
// entered after an arithmetic op that overflowed.
module ula_op_sequencer
    import ula_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  OP_VALID_IN,
    output logic                  OP_READY_OUT,
    input  logic [3:0]            OP_CODE_IN,
    output logic                  DONE_OUT,
    output logic                  ERR_OUT,
    input  logic                  TOS_SET_IN,
    input  logic [ADDR_WIDTH-1:0] TOS_SET_VAL_IN,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic [ADDR_WIDTH-1:0] STACK_ADDR_OUT,
    output logic                  STACK_WR_OUT,
    output logic                  CTRL_REG_OP1_OUT,
    output logic                  CTRL_REG_OP2_OUT,
    output logic                  CTRL_REG_OVERFLOW_OUT,
    output logic                  CTRL_STACK_COMP_OUT,
    output logic [3:0]            SEL_ULA_OUT,
`ifdef ULA_SEQ_OVF_TRAP_EN
    output logic                  TRAP_OUT,
    input  logic                  TRAP_CLR_IN,
`endif
    input  logic                  OVF_IN
);

    state_e                  state_q, state_d;
    logic [3:0]              op_q;
    logic [ADDR_WIDTH-1:0]   tos_q;
    logic                    err_q;

    logic [3:0]              dec_op;
    logic [1:0]              dec_arity;
    logic                    dec_arith, dec_cmp, dec_unary, dec_illegal;
    logic                    accept, reject;
    logic [ADDR_WIDTH-1:0]   tos_m1, tos_m2;

    // In IDLE classify the incoming request; afterwards the latched opcode.
    assign dec_op = (state_q == ST_IDLE) ? OP_CODE_IN : op_q;

    ula_op_decode u_dec (
        .op_code    (dec_op),
        .arity      (dec_arity),
        .is_arith   (dec_arith),
        .is_cmp     (dec_cmp),
        .is_unary   (dec_unary),
        .is_illegal (dec_illegal)
    );

    assign accept = OP_VALID_IN && OP_READY_OUT;
    assign reject = dec_illegal || (tos_q < ADDR_WIDTH'(dec_arity));
    assign tos_m1 = tos_q - ADDR_WIDTH'(1);
    assign tos_m2 = tos_q - ADDR_WIDTH'(2);

`ifndef ULA_SEQ_OVF_TRAP_EN
    logic unused_ovf;
    assign unused_ovf = OVF_IN;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 4'h0;
            tos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= accept && reject;
            if (accept && !reject)
                op_q <= OP_CODE_IN;
            if (state_q == ST_IDLE && TOS_SET_IN)
                tos_q <= TOS_SET_VAL_IN;
            else if (state_q == ST_EXEC && !dec_unary)
                tos_q <= tos_m1;   // two operands consumed, one result pushed
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && !reject) state_d = ST_RD1;
            ST_RD1:  state_d = ST_LD1;
            ST_LD1:  state_d = dec_unary ? ST_EXEC : ST_LD2;
            ST_LD2:  state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
`ifdef ULA_SEQ_OVF_TRAP_EN
            ST_DONE: state_d = (dec_arith && OVF_IN) ? ST_HALT : ST_IDLE;
            ST_HALT: if (TRAP_CLR_IN) state_d = ST_IDLE;
`else
            ST_DONE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low whenever rst_n is low so that an operation cut
    // off by reset can never write the stack or report completion.
    always_comb begin
        OP_READY_OUT          = 1'b0;
        DONE_OUT              = 1'b0;
        ERR_OUT               = 1'b0;
        TOS_OUT               = '0;
        STACK_ADDR_OUT        = '0;
        STACK_WR_OUT          = 1'b0;
        CTRL_REG_OP1_OUT      = 1'b0;
        CTRL_REG_OP2_OUT      = 1'b0;
        CTRL_REG_OVERFLOW_OUT = 1'b0;
        CTRL_STACK_COMP_OUT   = 1'b0;
        SEL_ULA_OUT           = 4'h0;
`ifdef ULA_SEQ_OVF_TRAP_EN
        TRAP_OUT              = 1'b0;
`endif
        if (rst_n) begin
            TOS_OUT = tos_q;
            ERR_OUT = err_q;
            case (state_q)
                ST_IDLE: OP_READY_OUT = !TOS_SET_IN;
                ST_RD1:  STACK_ADDR_OUT = tos_m1;
                ST_LD1: begin
                    CTRL_REG_OP1_OUT = 1'b1;
                    STACK_ADDR_OUT   = tos_m2;
                    SEL_ULA_OUT      = op_q;
                end
                ST_LD2: begin
                    CTRL_REG_OP2_OUT = 1'b1;
                    STACK_ADDR_OUT   = tos_m2;
                    SEL_ULA_OUT      = op_q;
                end
                ST_EXEC: begin
                    SEL_ULA_OUT           = op_q;
                    STACK_ADDR_OUT        = dec_unary ? tos_m1 : tos_m2;
                    STACK_WR_OUT          = 1'b1;
                    CTRL_REG_OVERFLOW_OUT = dec_arith;
                    CTRL_STACK_COMP_OUT   = dec_cmp;
                end
                ST_DONE: begin
                    DONE_OUT    = 1'b1;
                    SEL_ULA_OUT = op_q;
                end
`ifdef ULA_SEQ_OVF_TRAP_EN
                ST_HALT: TRAP_OUT = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Scoreboard bench for ula_op_sequencer: stimulus pushes the expected output
// events (operand loads, stack write, done, error) with the cycle they must
// appear in; a monitor on the falling edge pops and compares each event.
module tb_ula_op_sequencer;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid, op_ready;
    logic [3:0]    op_code;
    logic          done, err;
    logic          tos_set;
    logic [AW-1:0] tos_set_val, tos, stack_addr;
    logic          stack_wr, op1_en, op2_en, ovf_en, comp_en;
    logic [3:0]    sel;
    logic          ovf_in;
`ifdef ULA_SEQ_OVF_TRAP_EN
    logic          trap, trap_clr;
`endif

    always #5 clk = ~clk;

    ula_op_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .OP_VALID_IN           (op_valid),
        .OP_READY_OUT          (op_ready),
        .OP_CODE_IN            (op_code),
        .DONE_OUT              (done),
        .ERR_OUT               (err),
        .TOS_SET_IN            (tos_set),
        .TOS_SET_VAL_IN        (tos_set_val),
        .TOS_OUT               (tos),
        .STACK_ADDR_OUT        (stack_addr),
        .STACK_WR_OUT          (stack_wr),
        .CTRL_REG_OP1_OUT      (op1_en),
        .CTRL_REG_OP2_OUT      (op2_en),
        .CTRL_REG_OVERFLOW_OUT (ovf_en),
        .CTRL_STACK_COMP_OUT   (comp_en),
        .SEL_ULA_OUT           (sel),
`ifdef ULA_SEQ_OVF_TRAP_EN
        .TRAP_OUT              (trap),
        .TRAP_CLR_IN           (trap_clr),
`endif
        .OVF_IN                (ovf_in)
    );

    localparam int EV_OP1 = 0, EV_OP2 = 1, EV_WR = 2, EV_DONE = 3, EV_ERR = 4;

    typedef struct {
        int            kind;
        int            cyc;
        logic [AW-1:0] addr;
        logic          ovf;
        logic          cmp;
        logic [3:0]    sel;
    } ev_t;

    ev_t           sb[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    bit            mon_en = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic push(input int kind, input int c, input logic [AW-1:0] addr,
                        input logic ovf, input logic cmp, input logic [3:0] s);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.ovf = ovf; e.cmp = cmp; e.sel = s;
        sb.push_back(e);
    endtask

    // Operand-load events report the address presented the cycle before,
    // i.e. the stack entry whose read data the register captures.
    task automatic mon_ev(input int kind, input logic [AW-1:0] addr);
        ev_t e;
        n_chk++;
        if (sb.size() == 0) begin
            $display("FAIL event: unexpected kind %0d at cycle %0d addr %0h", kind, cyc, addr);
        end else begin
            e = sb.pop_front();
            if (e.kind == kind && e.cyc == cyc && e.addr == addr && e.ovf == ovf_en &&
                e.cmp == comp_en && e.sel == sel)
                n_pass++;
            else
                $display("FAIL event: got kind %0d cyc %0d addr %0h ovf %0b cmp %0b sel %0h, expected kind %0d cyc %0d addr %0h ovf %0b cmp %0b sel %0h",
                         kind, cyc, addr, ovf_en, comp_en, sel,
                         e.kind, e.cyc, e.addr, e.ovf, e.cmp, e.sel);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (op1_en)   mon_ev(EV_OP1, prev_addr);
            if (op2_en)   mon_ev(EV_OP2, prev_addr);
            if (stack_wr) mon_ev(EV_WR, stack_addr);
            if (done)     mon_ev(EV_DONE, '0);
            if (err)      mon_ev(EV_ERR, '0);
        end
        prev_addr <= stack_addr;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_tos(input logic [AW-1:0] v);
        tos_set = 1'b1; tos_set_val = v;
        tick();
        tos_set = 1'b0;
    endtask

    // Presents a request for one cycle; n is the cycle of the accepting edge.
    task automatic issue(input logic [3:0] code, output int n);
        n = cyc;
        op_valid = 1'b1; op_code = code;
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; op_valid = 1'b0; op_code = 4'h0; tos_set = 1'b0;
        tos_set_val = '0; ovf_in = 1'b0;
`ifdef ULA_SEQ_OVF_TRAP_EN
        trap_clr = 1'b0;
`endif
        repeat (2) tick();
        check("rst_ready", 32'(op_ready), 32'd0);
        check("rst_tos",   32'(tos),      32'd0);
        check("rst_sel",   32'(sel),      32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(op_ready), 32'd1);
        mon_en = 1;
        tick();

        // ADD at depth 5
        tos_set = 1'b1; tos_set_val = 12'd5;
        #1 check("ready_during_set", 32'(op_ready), 32'd0);
        tick(); tos_set = 1'b0;
        check("tos_load5", 32'(tos), 32'd5);
        issue(4'h0, n);
        push(EV_OP1,  n + 2, 12'd4, 1'b0, 1'b0, 4'h0);
        push(EV_OP2,  n + 3, 12'd3, 1'b0, 1'b0, 4'h0);
        push(EV_WR,   n + 4, 12'd3, 1'b1, 1'b0, 4'h0);
        push(EV_DONE, n + 5, 12'd0, 1'b0, 1'b0, 4'h0);
        check("busy_ready", 32'(op_ready), 32'd0);
        repeat (5) tick();
        check("add_tos", 32'(tos), 32'd4);
        check("add_ready_after", 32'(op_ready), 32'd1);

        // NOT at depth 1
        set_tos(12'd1);
        issue(4'h8, n);
        push(EV_OP1,  n + 2, 12'd0, 1'b0, 1'b0, 4'h8);
        push(EV_WR,   n + 3, 12'd0, 1'b0, 1'b0, 4'h8);
        push(EV_DONE, n + 4, 12'd0, 1'b0, 1'b0, 4'h8);
        repeat (4) tick();
        check("not_tos", 32'(tos), 32'd1);

        // SUB underflow at depth 1
        issue(4'h1, n);
        push(EV_ERR, n + 1, 12'd0, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        check("sub_uf_tos", 32'(tos), 32'd1);

        // illegal code at depth 3
        set_tos(12'd3);
        issue(4'hF, n);
        push(EV_ERR, n + 1, 12'd0, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        check("illegal_tos", 32'(tos), 32'd3);

        // EQ at depth 2
        set_tos(12'd2);
        issue(4'h9, n);
        push(EV_OP1,  n + 2, 12'd1, 1'b0, 1'b0, 4'h9);
        push(EV_OP2,  n + 3, 12'd0, 1'b0, 1'b0, 4'h9);
        push(EV_WR,   n + 4, 12'd0, 1'b0, 1'b1, 4'h9);
        push(EV_DONE, n + 5, 12'd0, 1'b0, 1'b0, 4'h9);
        repeat (5) tick();
        check("eq_tos", 32'(tos), 32'd1);

        // TOS load wins over a simultaneous request
        tos_set = 1'b1; tos_set_val = 12'd7; op_valid = 1'b1; op_code = 4'h0;
        tick();
        tos_set = 1'b0; op_valid = 1'b0;
        repeat (6) tick();
        check("set_vs_op_tos", 32'(tos), 32'd7);

        // address arithmetic at the top of the range
        set_tos(12'hFFF);
        issue(4'h0, n);
        push(EV_OP1,  n + 2, 12'hFFE, 1'b0, 1'b0, 4'h0);
        push(EV_OP2,  n + 3, 12'hFFD, 1'b0, 1'b0, 4'h0);
        push(EV_WR,   n + 4, 12'hFFD, 1'b1, 1'b0, 4'h0);
        push(EV_DONE, n + 5, 12'd0,   1'b0, 1'b0, 4'h0);
        repeat (5) tick();
        check("wrap_tos", 32'(tos), 32'hFFE);

        // NOT on empty stack
        set_tos(12'd0);
        issue(4'h8, n);
        push(EV_ERR, n + 1, 12'd0, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        check("not_uf_tos", 32'(tos), 32'd0);

        // reset during LD2 abandons the op
        set_tos(12'd5);
        issue(4'h0, n);
        push(EV_OP1, n + 2, 12'd4, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1 check("rst_ld2_wr", 32'(stack_wr), 32'd0);
        repeat (2) tick();
        check("rst_ld2_tos", 32'(tos), 32'd0);
        check("rst_ld2_ready", 32'(op_ready), 32'd0);
        rst_n = 1'b1;
        #1 check("rst_ld2_idle", 32'(op_ready), 32'd1);
        repeat (6) tick();

`ifdef ULA_SEQ_OVF_TRAP_EN
        // MUL overflow traps until cleared
        set_tos(12'd2);
        ovf_in = 1'b1;
        issue(4'h2, n);
        push(EV_OP1,  n + 2, 12'd1, 1'b0, 1'b0, 4'h2);
        push(EV_OP2,  n + 3, 12'd0, 1'b0, 1'b0, 4'h2);
        push(EV_WR,   n + 4, 12'd0, 1'b1, 1'b0, 4'h2);
        push(EV_DONE, n + 5, 12'd0, 1'b0, 1'b0, 4'h2);
        repeat (5) tick();
        check("trap_set", 32'(trap), 32'd1);
        check("trap_ready", 32'(op_ready), 32'd0);
        repeat (3) tick();
        check("trap_hold", 32'(trap), 32'd1);
        trap_clr = 1'b1;
        tick();
        trap_clr = 1'b0; ovf_in = 1'b0;
        check("trap_clr", 32'(trap), 32'd0);
        check("trap_clr_ready", 32'(op_ready), 32'd1);
        check("trap_tos", 32'(tos), 32'd1);
`else
        // overflow flag has no effect without the trap
        set_tos(12'd2);
        ovf_in = 1'b1;
        issue(4'h2, n);
        push(EV_OP1,  n + 2, 12'd1, 1'b0, 1'b0, 4'h2);
        push(EV_OP2,  n + 3, 12'd0, 1'b0, 1'b0, 4'h2);
        push(EV_WR,   n + 4, 12'd0, 1'b1, 1'b0, 4'h2);
        push(EV_DONE, n + 5, 12'd0, 1'b0, 1'b0, 4'h2);
        repeat (5) tick();
        ovf_in = 1'b0;
        check("ovf_ignored_ready", 32'(op_ready), 32'd1);
        check("mul_tos", 32'(tos), 32'd1);
`endif

        repeat (3) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
